aes_key_expand_ctrl: RTL and testbench

//  Sequences AES-128 key expansion (FIPS-197 sec. 5.2): accepts a 128-bit cipher key on a

---
 rtl/aes_pkg.sv | 53 +++++
 rtl/sub_word.sv | 20 ++
 rtl/aes_key_expand_ctrl.sv | 175 +++++++++++++++++
 tb/tb_aes_key_expand_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
//   Shared AES-128 key-schedule definitions: key/round geometry, Rcon seed and
//   reduction polynomial, expansion FSM encoding, the forward S-box table and
//   the GF(2^8) xtime helper.
//   No ports; imported with "import aes_pkg::*;".
// ----------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_NK        = 4;
    localparam int AES_NR        = 10;
    localparam int AES_NUM_WORDS = 4 * (AES_NR + 1);

    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] XTIME_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [7:0] SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Forward S-box lookup of one byte.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[b];
    endfunction

    // Multiply by x in GF(2^8): shift left, reduce when the old MSB falls out.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/sub_word.sv
// ----------------------------------------------------------------------------
// sub_word
//   Combinational SubWord: four parallel S-box lookups, byte order preserved
//   (byte 0 stays in the most significant lane).
//   Ports:
//     word_in   in  [31:0]  word to substitute
//     word_out  out [31:0]  S-box image of each byte of word_in
// ----------------------------------------------------------------------------
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    for (genvar b = 0; b < 4; b++) begin : g_lane
        assign word_out[8*b +: 8] = sbox(word_in[8*b +: 8]);
    end

endmodule

// File: rtl/aes_key_expand_ctrl.sv
// ----------------------------------------------------------------------------
// aes_key_expand_ctrl
//   AES-128 key-expansion sequencer. Latches a 128-bit key on start and emits
//   round-key words w[0..43], one per accepted beat, on a valid/ready port.
//   Holds the expansion FSM, word index, Rcon register and a 4-word history
//   window; SubWord is done by the sub_word instance.
//   Ports:
//     clk       in   rising-edge clock
//     reset     in   asynchronous reset, active-low
//     start     in   begin an expansion (only honoured in IDLE)
//     key_in    in   [0:127] cipher key, bits [0:31] = w[0]
//     busy      out  high from the cycle after start until DONE has passed
//     done      out  one-cycle pulse after w[43] is accepted
//     wk_valid  out  wk_index/wk_data carry a word
//     wk_ready  in   consumer takes the word this cycle
//     wk_index  out  word number 0..43
//     wk_data   out  [0:31] w[i], byte 0 in bits [0:7]
// ----------------------------------------------------------------------------
module aes_key_expand_ctrl
    import aes_pkg::*;
#(
    parameter int NK    = AES_NK,   // only 4 is supported
    parameter int NR    = AES_NR,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [0:127]     key_in,
    output logic             busy,
    output logic             done,
    output logic             wk_valid,
    input  logic             wk_ready,
    output logic [IDX_W-1:0] wk_index,
    output logic [0:31]      wk_data
);

    localparam int               NUM_WORDS = 4 * (NR + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0] KEY_WORDS = IDX_W'(NK);

    state_e            state_q, state_d;
    logic [3:0][31:0]  win_q,   win_d;     // win[0] is the oldest word
    logic [7:0]        rcon_q,  rcon_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [31:0]       data_q,  data_d;
    logic              valid_q, valid_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic              accept;
    logic [3:0][31:0]  win_shift;
    logic [IDX_W-1:0]  idx_nxt;
    logic              round_word;
    logic [31:0]       rot_word;
    logic [31:0]       sub_out;
    logic [31:0]       temp;
    logic [31:0]       exp_word;

    assign accept   = valid_q && wk_ready;
    assign rot_word = {data_q[23:0], data_q[31:24]};

    sub_word u_sub_word (
        .word_in  (rot_word),
        .word_out (sub_out)
    );

    // Next-word datapath. The window is shifted with the word being accepted,
    // so after the shift win[0] = w[i-3] and data_q = w[i], which is exactly
    // what w[i+1] needs. During LOAD the window was seeded with the key, so the
    // same shift rotates the key words and win_shift[0] is the next key word;
    // after the fourth shift the window is back to w[0..3].
    always_comb begin
        win_shift  = {data_q, win_q[3:1]};
        idx_nxt    = idx_q + IDX_W'(1);
        round_word = (idx_nxt[1:0] == 2'b00);
        temp       = data_q;
        if (round_word) begin
            temp = sub_out ^ {rcon_q, 24'h00_0000};
        end
        exp_word   = win_shift[0] ^ temp;
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves it unassigned
        // (which would infer a latch) and "hold" is the default behaviour.
        state_d = state_q;
        win_d   = win_q;
        rcon_d  = rcon_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    for (int k = 0; k < 4; k++) begin
                        win_d[k] = key_in[32*k +: 32];
                    end
                    data_d  = key_in[0:31];
                    idx_d   = '0;
                    rcon_d  = RCON_INIT;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            LOAD, EXPAND: begin
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        // Final word taken: index stays at 43, no new word.
                        state_d = DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        win_d = win_shift;
                        idx_d = idx_nxt;
                        if (idx_nxt < KEY_WORDS) begin
                            data_d = win_shift[0];
                        end else begin
                            state_d = EXPAND;
                            data_d  = exp_word;
                            if (round_word) begin
                                rcon_d = xtime(rcon_q);
                            end
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            // NOTE: the key window holds key material, so it is cleared on
            // reset rather than left with the previous key in it.
            win_q   <= '0;
            rcon_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            rcon_q  <= rcon_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign wk_valid = valid_q;
    assign wk_index = idx_q;
    assign wk_data  = data_q;

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// ----------------------------------------------------------------------------
// tb_aes_key_expand_ctrl
//   Directed bench for aes_key_expand_ctrl. Expected words come from the
//   FIPS-197 vectors written below and from a small key-schedule model whose
//   S-box is derived from GF(2^8) inversion plus the affine map.
// ----------------------------------------------------------------------------
module tb_aes_key_expand_ctrl;

    localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_ZERO = 128'h0;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         wk_valid;
    logic         wk_ready;
    logic [5:0]   wk_index;
    logic [31:0]  wk_data;

    int           vectors;
    int           miscompares;

    logic [7:0]   tb_sbox  [256];
    logic [31:0]  exp_w    [44];
    logic [31:0]  got_w    [44];
    int           run_beats;
    int           run_dones;

    aes_key_expand_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .done     (done),
        .wk_valid (wk_valid),
        .wk_ready (wk_ready),
        .wk_index (wk_index),
        .wk_data  (wk_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic string tg(input int t, input string s, input int n);
        return $sformatf("t%0d_%s%0d", t, s, n);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                       ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model(input logic [127:0] key);
        logic [7:0]  rc;
        logic [31:0] t;
        rc = 8'h01;
        for (int k = 0; k < 4; k++) exp_w[k] = key[127 - 32*k -: 32];
        for (int i = 4; i < 44; i++) begin
            t = exp_w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            exp_w[i] = exp_w[i-4] ^ t;
        end
    endtask

    // One expansion run. ready_mode 0: ready held high, 1: random ready.
    // event_kind 1: pulse start and change key_in at event_beat (and in DONE);
    // event_kind 2: asynchronous reset at event_beat.
    task automatic run(input int t, input logic [127:0] key, input int ready_mode,
                       input int event_beat, input int event_kind);
        int          beat;
        int          dones;
        logic        held;
        logic        finished;
        logic        aborted;
        logic [5:0]  held_idx;
        logic [31:0] held_data;

        model(key);
        for (int k = 0; k < 44; k++) got_w[k] = 'x;
        beat = 0; dones = 0; held = 1'b0; finished = 1'b0; aborted = 1'b0;
        held_idx = '0; held_data = '0;

        key_in = key;
        start  = 1'b1;
        step();

        for (int cyc = 1; cyc < 400; cyc++) begin
            start = 1'b0;
            if (dones != 0) begin
                check(tg(t, "done_len", cyc), 64'(done), 64'd0);
                check(tg(t, "busy_off", cyc), 64'(busy), 64'd0);
                check(tg(t, "idle_valid", cyc), 64'(wk_valid), 64'd0);
                finished = 1'b1;
                break;
            end
            if (cyc == 1) begin
                check(tg(t, "busy_on", cyc), 64'(busy), 64'd1);
                check(tg(t, "first_valid", cyc), 64'(wk_valid), 64'd1);
            end
            if (held) begin
                check(tg(t, "hold_valid", cyc), 64'(wk_valid), 64'd1);
                check(tg(t, "hold_idx", cyc), 64'(wk_index), 64'(held_idx));
                check(tg(t, "hold_data", cyc), 64'(wk_data), 64'(held_data));
            end
            if (done) begin
                dones++;
                check(tg(t, "done_beats", cyc), 64'(beat), 64'd44);
                check(tg(t, "done_valid", cyc), 64'(wk_valid), 64'd0);
                check(tg(t, "done_busy", cyc), 64'(busy), 64'd1);
                if (ready_mode == 0) check(tg(t, "done_cycle", cyc), 64'(cyc), 64'd45);
                if (event_kind == 1) start = 1'b1;
            end
            if (wk_valid) begin
                if (beat < 44) begin
                    check(tg(t, "idx", beat), 64'(wk_index), 64'(beat));
                    check(tg(t, "w", beat), 64'(wk_data), 64'(exp_w[beat]));
                end else begin
                    check(tg(t, "extra_beat", beat), 64'(beat), 64'd43);
                end
            end
            if (event_kind == 2 && beat == event_beat && wk_valid) begin
                #3;
                reset = 1'b0;
                #1;
                check(tg(t, "rst_busy", beat), 64'(busy), 64'd0);
                check(tg(t, "rst_done", beat), 64'(done), 64'd0);
                check(tg(t, "rst_valid", beat), 64'(wk_valid), 64'd0);
                check(tg(t, "rst_idx", beat), 64'(wk_index), 64'd0);
                check(tg(t, "rst_data", beat), 64'(wk_data), 64'd0);
                step();
                check(tg(t, "rst_hold_done", beat), 64'(done), 64'd0);
                check(tg(t, "rst_hold_valid", beat), 64'(wk_valid), 64'd0);
                reset = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (event_kind == 1 && beat == event_beat && wk_valid) begin
                start  = 1'b1;
                key_in = ~key;
            end
            wk_ready  = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            held      = wk_valid && !wk_ready;
            held_idx  = wk_index;
            held_data = wk_data;
            if (wk_valid && wk_ready) begin
                if (beat < 44) got_w[beat] = wk_data;
                beat++;
            end
            step();
        end
        if (!finished && !aborted) check(tg(t, "timeout", 0), 64'(finished), 64'd1);
        run_beats = beat;
        run_dones = dones;
        start     = 1'b0;
        wk_ready  = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start       = 1'b0;
        wk_ready    = 1'b1;
        key_in      = '0;
        build_sbox();

        #1 reset = 1'b0;
        #2;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_valid", 64'(wk_valid), 64'd0);
        check("reset_idx", 64'(wk_index), 64'd0);
        check("reset_data", 64'(wk_data), 64'd0);
        step();
        reset = 1'b1;
        step();

        // 1: FIPS-197 key, ready high.
        run(1, KEY_FIPS, 0, 0, 0);
        check("t1_w0", 64'(got_w[0]), 64'h2b7e1516);
        check("t1_w1", 64'(got_w[1]), 64'h28aed2a6);
        check("t1_w2", 64'(got_w[2]), 64'habf71588);
        check("t1_w3", 64'(got_w[3]), 64'h09cf4f3c);
        check("t1_w4", 64'(got_w[4]), 64'ha0fafe17);
        check("t1_w5", 64'(got_w[5]), 64'h88542cb1);
        check("t1_w43", 64'(got_w[43]), 64'hb6630ca6);
        check("t1_dones", 64'(run_dones), 64'd1);

        // 2: all-zero key, back to back with run 1.
        run(2, KEY_ZERO, 0, 0, 0);
        check("t2_w4", 64'(got_w[4]), 64'h62636363);
        check("t2_w8", 64'(got_w[8]), 64'h9b9898c9);
        check("t2_w43", 64'(got_w[43]), 64'h6f8f188e);
        check("t2_beats", 64'(run_beats), 64'd44);

        // 3: FIPS key under random back-pressure.
        run(3, KEY_FIPS, 1, 0, 0);
        check("t3_w4", 64'(got_w[4]), 64'ha0fafe17);
        check("t3_w43", 64'(got_w[43]), 64'hb6630ca6);
        check("t3_dones", 64'(run_dones), 64'd1);

        // 4: start pulses and key_in change mid-run and in DONE.
        run(4, KEY_FIPS, 0, 10, 1);
        check("t4_w43", 64'(got_w[43]), 64'hb6630ca6);
        check("t4_beats", 64'(run_beats), 64'd44);
        step();
        check("t4_no_restart", 64'(busy), 64'd0);

        // 5: asynchronous reset at beat 20, then a full zero-key run.
        run(5, KEY_FIPS, 0, 20, 2);
        check("t5_abort_dones", 64'(run_dones), 64'd0);
        run(5, KEY_ZERO, 0, 0, 0);
        check("t5_w4", 64'(got_w[4]), 64'h62636363);
        check("t5_w43", 64'(got_w[43]), 64'h6f8f188e);

        // 6: back-to-back runs, Rcon must restart for the second one.
        run(6, KEY_ZERO, 0, 0, 0);
        run(6, KEY_FIPS, 0, 0, 0);
        check("t6_w4", 64'(got_w[4]), 64'ha0fafe17);
        check("t6_w43", 64'(got_w[43]), 64'hb6630ca6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
